// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM and the datapath muxes it steers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (slave) and the datapath/memory side (master).
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_wr;
  logic       pc_wr_cond;
  logic       ir_wr;
  logic       reg_wr;
  logic       mem_rd;
  logic       mem_wr;
  logic       iord;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output opcode, zero, mem_ready,
    input  pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_rd, mem_wr, iord, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done,
           illegal, state
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_rd, mem_wr, iord, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done,
           illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: Moore-decoded selects and enables,
// with fetch and data-memory states stretched until mem_ready.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.slave bus
);

  state_e state_q;
  state_e state_d;
  ctrl_t  dec_s;
  ctrl_t  out_s;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode from the current state.
  always_comb begin
    state_d = S_FETCH;
    dec_s   = '0;
    case (state_q)
      S_FETCH: begin
        dec_s.mem_rd    = 1'b1;
        dec_s.alu_src_b = SRCB_FOUR;
        dec_s.ir_wr     = bus.mem_ready;
        dec_s.pc_wr     = bus.mem_ready;
        state_d         = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        dec_s.alu_src_b = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default: begin
            dec_s.illegal = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        dec_s.alu_src_a = 1'b1;
        dec_s.alu_src_b = SRCB_IMM;
        state_d         = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        dec_s.mem_rd = 1'b1;
        dec_s.iord   = 1'b1;
        state_d      = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        dec_s.reg_wr     = 1'b1;
        dec_s.reg_dst    = RD_RT;
        dec_s.mem_to_reg = M2R_MDR;
        dec_s.instr_done = 1'b1;
      end
      S_MEMWR: begin
        dec_s.mem_wr     = 1'b1;
        dec_s.iord       = 1'b1;
        dec_s.instr_done = bus.mem_ready;
        state_d          = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        dec_s.alu_src_a = 1'b1;
        dec_s.alu_src_b = SRCB_B;
        dec_s.alu_op    = ALUOP_FUNCT;
        state_d         = S_ALUWB;
      end
      S_ALUWB: begin
        dec_s.reg_wr     = 1'b1;
        dec_s.reg_dst    = RD_RD;
        dec_s.mem_to_reg = M2R_ALUOUT;
        dec_s.instr_done = 1'b1;
      end
      S_BRANCH: begin
        dec_s.alu_src_a  = 1'b1;
        dec_s.alu_src_b  = SRCB_B;
        dec_s.alu_op     = ALUOP_SUB;
        dec_s.pc_src     = PCSRC_ALUOUT;
        dec_s.pc_wr_cond = 1'b1;
        dec_s.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        dec_s.alu_src_a = 1'b1;
        dec_s.alu_src_b = SRCB_IMM;
        dec_s.alu_op    = ALUOP_ADD;
        state_d         = S_ADDIWB;
      end
      S_ADDIWB: begin
        dec_s.reg_wr     = 1'b1;
        dec_s.reg_dst    = RD_RT;
        dec_s.mem_to_reg = M2R_ALUOUT;
        dec_s.instr_done = 1'b1;
      end
      S_JUMP: begin
        dec_s.pc_wr      = 1'b1;
        dec_s.pc_src     = PCSRC_JUMP;
        dec_s.instr_done = 1'b1;
      end
      // PC already holds PC+4 here, so $31 gets the return address on the jump edge.
      S_JAL: begin
        dec_s.pc_wr      = 1'b1;
        dec_s.pc_src     = PCSRC_JUMP;
        dec_s.reg_wr     = 1'b1;
        dec_s.reg_dst    = RD_RA;
        dec_s.mem_to_reg = M2R_PC;
        dec_s.instr_done = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset gates every control output in the same cycle it is asserted.
  always_comb begin
    if (rst_n) begin
      out_s = dec_s;
    end else begin
      out_s = '0;
    end
  end

  assign bus.pc_wr      = out_s.pc_wr;
  assign bus.pc_wr_cond = out_s.pc_wr_cond;
  assign bus.ir_wr      = out_s.ir_wr;
  assign bus.reg_wr     = out_s.reg_wr;
  assign bus.mem_rd     = out_s.mem_rd;
  assign bus.mem_wr     = out_s.mem_wr;
  assign bus.iord       = out_s.iord;
  assign bus.reg_dst    = out_s.reg_dst;
  assign bus.mem_to_reg = out_s.mem_to_reg;
  assign bus.alu_src_a  = out_s.alu_src_a;
  assign bus.alu_src_b  = out_s.alu_src_b;
  assign bus.alu_op     = out_s.alu_op;
  assign bus.pc_src     = out_s.pc_src;
  assign bus.instr_done = out_s.instr_done;
  assign bus.illegal    = out_s.illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction state/output expectations built from
// the instruction-class sequencing rules, checked every cycle on the falling edge.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  int   n;

  logic [23:0] expq[$];
  logic [23:0] trace[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dut_vec();
    return {bus.state, bus.pc_wr, bus.pc_wr_cond, bus.ir_wr, bus.reg_wr, bus.mem_rd,
            bus.mem_wr, bus.iord, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_src, bus.instr_done, bus.illegal};
  endfunction

  // Expected outputs for a state, from the per-state output table of the controller.
  function automatic logic [23:0] spec_out(input logic r, input logic mr,
                                           input logic [5:0] op, input logic [3:0] st);
    logic pw, pwc, irw, rw, mrd, mwr, iord, a, done, ill;
    logic [1:0] rd, m2r, b, aop, psrc;
    {pw, pwc, irw, rw, mrd, mwr, iord, a, done, ill} = 10'd0;
    {rd, m2r, b, aop, psrc} = 10'd0;
    case (st)
      4'd0:  begin mrd = 1'b1; b = 2'b01; irw = mr; pw = mr; end
      4'd1:  begin
        b = 2'b11;
        ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 ||
                op == 6'b001000 || op == 6'b000010 || op == 6'b000011);
      end
      4'd2:  begin a = 1'b1; b = 2'b10; end
      4'd3:  begin mrd = 1'b1; iord = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 2'b01; done = 1'b1; end
      4'd5:  begin mwr = 1'b1; iord = 1'b1; done = mr; end
      4'd6:  begin a = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rd = 2'b01; done = 1'b1; end
      4'd8:  begin a = 1'b1; aop = 2'b01; psrc = 2'b01; pwc = 1'b1; done = 1'b1; end
      4'd9:  begin a = 1'b1; b = 2'b10; end
      4'd10: begin rw = 1'b1; done = 1'b1; end
      4'd11: begin pw = 1'b1; psrc = 2'b10; done = 1'b1; end
      4'd12: begin pw = 1'b1; psrc = 2'b10; rw = 1'b1; rd = 2'b10; m2r = 2'b10; done = 1'b1; end
      default: ;
    endcase
    if (!r) return {st, 20'd0};
    return {st, pw, pwc, irw, rw, mrd, mwr, iord, rd, m2r, a, b, aop, psrc, done, ill};
  endfunction

  task automatic cyc(input logic r, input logic mr, input logic [5:0] op,
                     input logic z, input logic [3:0] st);
    @(posedge clk);
    #1;
    rst_n         = r;
    bus.mem_ready = mr;
    bus.opcode    = op;
    bus.zero      = z;
    expq.push_back(spec_out(r, mr, op, st));
    n++;
  endtask

  // One instruction: fetch (with fw wait cycles), decode, then the class-specific phases.
  task automatic instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    n = 0;
    trace.delete();
    repeat (fw) cyc(1'b1, 1'b0, op, z, 4'd0);
    cyc(1'b1, 1'b1, op, z, 4'd0);
    cyc(1'b1, 1'b0, op, z, 4'd1);
    case (op)
      6'b100011: begin
        cyc(1'b1, 1'b0, op, z, 4'd2);
        repeat (mw) cyc(1'b1, 1'b0, op, z, 4'd3);
        cyc(1'b1, 1'b1, op, z, 4'd3);
        cyc(1'b1, 1'b0, op, z, 4'd4);
      end
      6'b101011: begin
        cyc(1'b1, 1'b0, op, z, 4'd2);
        repeat (mw) cyc(1'b1, 1'b0, op, z, 4'd5);
        cyc(1'b1, 1'b1, op, z, 4'd5);
      end
      6'b000000: begin cyc(1'b1, 1'b0, op, z, 4'd6); cyc(1'b1, 1'b0, op, z, 4'd7); end
      6'b000100: cyc(1'b1, 1'b0, op, z, 4'd8);
      6'b001000: begin cyc(1'b1, 1'b0, op, z, 4'd9); cyc(1'b1, 1'b0, op, z, 4'd10); end
      6'b000010: cyc(1'b1, 1'b0, op, z, 4'd11);
      6'b000011: cyc(1'b1, 1'b0, op, z, 4'd12);
      default: ;
    endcase
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Per-cycle compare against the model queue.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [23:0] e;
      logic [23:0] g;
      e = expq.pop_front();
      g = dut_vec();
      trace.push_back(g);
      cyc_no++;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle%0d got %h expected %h", cyc_no, g, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'd0;
    bus.zero = 1'b0;
    @(posedge clk);
    cyc(1'b0, 1'b1, 6'd0, 1'b0, 4'd0);
    @(negedge clk);
    #1;

    instr(6'b100011, 0, 0, 1'b0);
    chk("lw_len", n, 5);
    chk("lw_trace_len", trace.size(), 5);
    for (int i = 0; i < 5 && i < trace.size(); i++) chk("lw_state", trace[i][23:20], i);

    instr(6'b100011, 0, 2, 1'b0);
    chk("lw_wait_len", n, 7);
    for (int i = 0; i < 6 && i < trace.size(); i++) chk("lw_no_early_regwr", trace[i][16], 0);

    instr(6'b101011, 1, 0, 1'b0);
    chk("sw_fetchwait_len", n, 5);
    instr(6'b000000, 0, 0, 1'b0);
    chk("rtype_len", n, 4);
    instr(6'b001000, 0, 0, 1'b0);
    chk("addi_len", n, 4);
    instr(6'b000100, 0, 0, 1'b0);
    chk("beq0_len", n, 3);
    instr(6'b000100, 0, 0, 1'b1);
    chk("beq1_len", n, 3);
    instr(6'b000010, 0, 0, 1'b1);
    chk("j_len", n, 3);
    instr(6'b000011, 0, 0, 1'b0);
    chk("jal_len", n, 3);
    if (trace.size() == 3) chk("jal_outputs", trace[2], 24'hC9140A);
    else chk("jal_trace_len", trace.size(), 3);

    instr(6'b111111, 0, 0, 1'b0);
    chk("illegal_len", n, 2);
    if (trace.size() == 2) chk("illegal_decode", trace[1], 24'h1000C1);
    else chk("illegal_trace_len", trace.size(), 2);
    instr(6'b000000, 0, 0, 1'b0);
    chk("rtype_after_illegal_len", n, 4);

    // Reset asserted during an sw write wait.
    trace.delete();
    cyc(1'b1, 1'b1, 6'b101011, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 6'b101011, 1'b0, 4'd1);
    cyc(1'b1, 1'b0, 6'b101011, 1'b0, 4'd2);
    cyc(1'b1, 1'b0, 6'b101011, 1'b0, 4'd5);
    cyc(1'b0, 1'b0, 6'b101011, 1'b0, 4'd5);
    cyc(1'b1, 1'b1, 6'b000000, 1'b0, 4'd0);
    @(negedge clk);
    #1;
    if (trace.size() == 6) begin
      chk("reset_drops_memwr", trace[4], 24'h500000);
      chk("fetch_after_reset", trace[5][23:20], 0);
    end else begin
      chk("reset_trace_len", trace.size(), 6);
    end
    cyc(1'b1, 1'b0, 6'b000000, 1'b0, 4'd1);
    cyc(1'b1, 1'b0, 6'b000000, 1'b0, 4'd6);
    cyc(1'b1, 1'b0, 6'b000000, 1'b0, 4'd7);
    instr(6'b100011, 0, 0, 1'b0);
    chk("lw_after_reset_len", n, 5);

    @(negedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. Sequences one instruction at a time through fetch, decode, execute, memory and writeback. Drives every datapath mux select (IorD, RegDst, MemtoReg, ALUSrcA/B, PCSource), register/memory write enables and ALU operation class. Stretches fetch and data-memory cycles until the memory handshake completes.

## Interface
- No parameters; all encodings are fixed constants in `mc_ctrl_pkg`.
- Reset (already decided): one clock; reset is synchronous and active-low.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 6: IR[31:26]; sampled in DECODE.
- `zero` in 1: ALU zero flag; qualifies `pc_wr_cond` externally (`pc_en = pc_wr | pc_wr_cond & zero`).
- `mem_ready` in 1: memory completes the current access this cycle.
- Write enables, each out 1: `pc_wr`, `pc_wr_cond`, `ir_wr`, `reg_wr`.
- `mem_rd`, `mem_wr` out 1: memory read/write strobes.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `reg_dst` out 2: 00 rt, 01 rd, 10 $31.
- `mem_to_reg` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `alu_src_a` out 1: 0 PC, 1 A.
- `alu_src_b` out 2: 00 B, 01 const 4, 10 signext imm, 11 signext imm<<2.
- `alu_op` out 2: 00 add, 01 sub, 10 use funct.
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `instr_done` out 1: pulse in the last cycle of each instruction.
- `illegal` out 1: pulse in DECODE on an unsupported opcode.
- `state` out 4: current state code, for debug and bench.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, jal 000011. Any other opcode is illegal.
- Moore outputs decoded from the state register. Any output not listed for a state is 0.
- FETCH(0): mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_wr=pc_wr=mem_ready. Stay while !mem_ready; otherwise go to DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - jal → JAL
  - illegal → FETCH with illegal=1
- MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD (lw) or MEMWR (sw); opcode is held stable by the IR.
- MEMRD(3): mem_rd=1, iord=1. Stay until mem_ready, then MEMWB.
- MEMWB(4): reg_wr=1, reg_dst=00, mem_to_reg=01, instr_done=1. Next FETCH.
- MEMWR(5): mem_wr=1, iord=1, held across wait cycles. On mem_ready, instr_done=1 and go to FETCH.
- EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
- ALUWB(7): reg_wr=1, reg_dst=01, mem_to_reg=00, instr_done=1. Next FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_wr_cond=1, instr_done=1. Next FETCH.
- ADDIEX(9): alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
- ADDIWB(10): reg_wr=1, reg_dst=00, mem_to_reg=00, instr_done=1. Next FETCH.
- JUMP(11): pc_wr=1, pc_src=10, instr_done=1. Next FETCH.
- JAL(12): pc_wr=1, pc_src=10, reg_wr=1, reg_dst=10, mem_to_reg=10, instr_done=1.
  - The register file captures the current PC (already PC+4) on the same edge the PC takes the target.
  - Next FETCH.
- Codes 13–15 are unreachable. If entered, go to FETCH next cycle with all outputs 0.

## Timing
- Reset: rst_n low at a rising edge forces state=FETCH.
- While rst_n is low, all enables, strobes and pulses are forced to 0 and all selects are 00/0. This gating is combinational, so a write in progress drops in the same cycle reset is asserted.
- First fetch is issued in the first cycle with rst_n high.
- Zero-wait latency (mem_ready held high), cycles FETCH to instr_done inclusive:
  - lw 5; sw 4; R-type 4; addi 4
  - beq 3; j 3; jal 3
  - illegal 2 (no instr_done)
- Each cycle with mem_ready low in FETCH, MEMRD or MEMWR adds one cycle. Strobes and selects hold their values during the wait.
- mem_ready is ignored in every other state.

## Structure
- `mc_ctrl_pkg` holds: state encodings (4-bit), opcode constants, and select codes for reg_dst, mem_to_reg, alu_src_b, alu_op and pc_src. The datapath mux instances share these select codes.
- Single module. Implement as a state register plus a combinational next-state/output decode. No sub-module.

## Test plan
- lw, mem_ready=1: state sequence 0,1,2,3,4; reg_wr=1 with reg_dst=00 and mem_to_reg=01 only in state 4; instr_done in cycle 5.
- lw, mem_ready low for 2 cycles in MEMRD: mem_rd=1 and iord=1 held 3 cycles; total 7 cycles; no reg_wr before MEMWB.
- beq: state 8 shows pc_wr_cond=1, pc_src=01, alu_op=01; sequence returns to FETCH in 3 cycles regardless of zero.
- jal: state 12 asserts pc_wr, reg_wr, reg_dst=10, mem_to_reg=10, pc_src=10 together; instr_done=1.
- Opcode 111111: illegal=1 in DECODE, no write enables, FETCH next cycle; a following R-type completes in 4 cycles.
- rst_n low during MEMWR wait: mem_wr drops that cycle; state=FETCH after the edge; fetch restarts with rst_n high.
